// File: rtl/dmem_pkg.sv
// Data-memory responder shared definitions.
// I/O address map and STATUS bit layout.
package dmem_pkg;

  localparam logic [31:0] IO_BASE     = 32'h8000_0000;
  localparam logic [31:0] GPIO_ADDR   = IO_BASE;
  localparam logic [31:0] CYCLE_ADDR  = IO_BASE + 32'h4;
  localparam logic [31:0] TXDATA_ADDR = IO_BASE + 32'h8;
  localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'hC;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Core data port plus TX byte stream.
// Master = core/console side, slave = responder.
interface dmem_responder_if;

  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_valid, tx_data
  );

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_valid, tx_data
  );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Byte FIFO for the console TX path.
// A push while full is still taken if a pop frees a slot.
module tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = empty ? 8'h00 : mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM plus GPIO,
// cycle counter and TX FIFO mapped at IO_BASE.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic [31:0]        gpio_out
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    ram [RAM_WORDS];
  logic [31:0]    wordAddr;
  logic [RAW-1:0] ramIdx;
  logic           isRam;
  logic           isGpio;
  logic           isCycle;
  logic           isTx;
  logic           isStatus;
  logic [31:0]    cycleCnt;
  logic           ovf;
  logic           fifoFull;
  logic           fifoEmpty;
  logic [CW-1:0]  fifoCount;
  logic [31:0]    cnt32;
  logic [3:0]     cnt4;
  logic [31:0]    status;
  logic           txPush;
  logic           txPop;

  assign wordAddr = bus.ALUResult & 32'hFFFF_FFFC;
  assign ramIdx   = wordAddr[RAW+1:2];
  assign isRam    = (wordAddr[31:RAW+2] == '0);
  assign isGpio   = (wordAddr == GPIO_ADDR);
  assign isCycle  = (wordAddr == CYCLE_ADDR);
  assign isTx     = (wordAddr == TXDATA_ADDR);
  assign isStatus = (wordAddr == STATUS_ADDR);

  assign txPush = bus.MemWrite && isTx;
  assign txPop  = bus.tx_valid && bus.tx_ready;

  tx_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (txPush),
    .din   (bus.WriteData[7:0]),
    .pop   (txPop),
    .dout  (bus.tx_data),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign bus.tx_valid = !fifoEmpty;

  // RAM has no reset; contents are undefined until stored
  always_ff @(posedge clk) begin
    if (bus.MemWrite && isRam) ram[ramIdx] <= bus.WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out <= '0;
      cycleCnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (bus.MemWrite && isGpio) gpio_out <= bus.WriteData;
      if (bus.MemWrite && isCycle) cycleCnt <= '0;
      else                         cycleCnt <= cycleCnt + 32'd1;
      if (bus.MemWrite && isStatus)        ovf <= 1'b0;
      else if (txPush && fifoFull && !txPop) ovf <= 1'b1;
    end
  end

  assign cnt32 = 32'(fifoCount);
  assign cnt4  = (cnt32 > 32'd15) ? 4'hF : cnt32[3:0];

  always_comb begin
    status                       = '0;
    status[ST_EMPTY]             = fifoEmpty;
    status[ST_FULL]              = fifoFull;
    status[ST_OVF]               = ovf;
    status[ST_COUNT_LSB +: 4]    = cnt4;
  end

  always_comb begin
    bus.ReadData = '0;
    unique case (1'b1)
      isRam:    bus.ReadData = ram[ramIdx];
      isGpio:   bus.ReadData = gpio_out;
      isCycle:  bus.ReadData = cycleCnt;
      isStatus: bus.ReadData = status;
      default:  bus.ReadData = '0;
    endcase
  end

endmodule
